// File: rtl/uart_axis_rx_if.sv
// uart_axis_rx_if: AXI-Stream beat bundle carrying one received UART word.
// tuser[0] = framing error, tuser[1] = parity error.
interface uart_axis_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 tvalid;
    logic                 tready;
    logic [DATA_BITS-1:0] tdata;
    logic [1:0]           tuser;

    modport master (
        output tvalid,
        output tdata,
        output tuser,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/uart_axis_rx.sv
// uart_axis_rx: configurable UART receiver with AXI-Stream output and drop count.
// Optional break pulse output enabled by `define UART_RX_BREAK_DETECT_EN.
module uart_axis_rx #(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  sresetn,
    input  logic                  serial_data,
    uart_axis_rx_if.master        m_axis,
    output logic [DROP_CNT_W-1:0] drop_count
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    output logic                  break_det
`endif
);
    localparam int DIV = CLK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t               state;
    logic                 sync1;
    logic                 sync2;
    logic                 line_q;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 ferr;
    logic                 perr;
    logic                 tvalid_q;
    logic [DATA_BITS-1:0] tdata_q;
    logic [1:0]           tuser_q;

    logic line;
    logic fall;
    logic expire;
    logic ferr_next;
    logic last_stop;
    logic accept;

    assign line      = sync2;
    assign fall      = line_q & ~line;
    assign expire    = (cnt == '0);
    assign ferr_next = ferr | ~line;
    assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
    assign accept    = ~tvalid_q | m_axis.tready;

    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tuser  = tuser_q;

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            line_q     <= 1'b1;
            state      <= S_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            shreg      <= '0;
            ferr       <= 1'b0;
            perr       <= 1'b0;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            tuser_q    <= '0;
            drop_count <= '0;
        end else begin
            sync1  <= serial_data;
            sync2  <= sync1;
            line_q <= sync2;
            if (tvalid_q && m_axis.tready) begin
                tvalid_q <= 1'b0;
            end
            unique case (state)
                S_IDLE: begin
                    if (fall) begin
                        state <= S_START;
                        cnt   <= HALF;
                    end
                end
                S_START: begin
                    if (!expire) begin
                        cnt <= cnt - 1'b1;
                    end else if (!line) begin
                        state   <= S_DATA;
                        cnt     <= FULL;
                        bit_cnt <= '0;
                        ferr    <= 1'b0;
                        perr    <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (!expire) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cnt     <= FULL;
                        shreg   <= {line, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'(DATA_BITS - 1)) begin
                            stop_cnt <= 1'b0;
                            state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (!expire) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cnt   <= FULL;
                        perr  <= ((^shreg) ^ line) == (PARITY == 2);
                        state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (!expire) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cnt      <= FULL;
                        ferr     <= ferr_next;
                        stop_cnt <= stop_cnt + 1'b1;
                        if (last_stop) begin
                            // A held, unaccepted word wins; the new one is lost.
                            if (accept) begin
                                tvalid_q <= 1'b1;
                                tdata_q  <= shreg;
                                tuser_q  <= {perr, ferr_next};
                            end else if (drop_count != '1) begin
                                drop_count <= drop_count + 1'b1;
                            end
                            state <= (ferr_next && !line) ? S_WAIT_HIGH
                                                          : S_IDLE;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    if (line) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    localparam int BRK = DIV * (1 + DATA_BITS + ((PARITY != 0) ? 1 : 0)
                                + STOP_BITS);
    localparam int LW  = $clog2(BRK + 1);

    logic [LW-1:0] low_cnt;

    // Saturating at BRK gives exactly one pulse per low period.
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            low_cnt   <= '0;
            break_det <= 1'b0;
        end else begin
            break_det <= 1'b0;
            if (line) begin
                low_cnt <= '0;
            end else if (low_cnt != LW'(BRK)) begin
                low_cnt   <= low_cnt + 1'b1;
                break_det <= (low_cnt == LW'(BRK - 1));
            end
        end
    end
`endif
endmodule
